req_arbiter4: RTL and testbench

REQ_ARBITER4 -- requirements
Module: req_arbiter4

---
 rtl/req_arbiter4.sv | 131 +++++++++++++
 tb/tb_req_arbiter4.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter4.sv
// req_arbiter4: 4-requester round-robin arbiter with registered one-hot grant and no preemption.
// Define ARB_TIMEOUT_EN to add a hold counter that force-releases an owner after HOLD_MAX cycles.
module req_arbiter4 #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] gnt_d;
   logic [1:0] idx_d;
   logic       vld_d;
   logic       arb_en;
   logic [1:0] base;
   logic [1:0] cand;
   logic       found;
   logic [1:0] win;
   logic       new_grant;
   logic       force_rel;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
      $error("req_arbiter4: HOLD_MAX must be in 1..255");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt     <= gnt_d;
         gnt_idx <= idx_d;
         gnt_vld <= vld_d;
      end
   end

   // A release moves the search base past the old owner on the same edge, so
   // a pending requester is granted back-to-back without an idle cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      idx_d   = gnt_idx;
      vld_d   = gnt_vld;
      arb_en  = 1'b0;
      base    = ptr_q;
      cand    = '0;
      found   = 1'b0;
      win     = '0;

      case (state_q)
         IDLE: arb_en = 1'b1;
         BUSY: begin
            if (!req[gnt_idx] || force_rel) begin
               ptr_d  = gnt_idx + 2'd1;
               base   = gnt_idx + 2'd1;
               arb_en = 1'b1;
            end
         end
         default: arb_en = 1'b1;
      endcase

      for (int unsigned i = 0; i < 4; i++) begin
         cand = base + 2'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end

      if (arb_en) begin
         if (found) begin
            state_d = BUSY;
            gnt_d   = 4'b0001 << win;
            idx_d   = win;
            vld_d   = 1'b1;
         end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            vld_d   = 1'b0;
         end
      end
   end

   assign new_grant = arb_en & found;

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_q;

   // hold_q is zero in the first granted cycle, so HOLD_MAX-1 marks the last allowed cycle.
   assign force_rel = (state_q == BUSY) && req[gnt_idx] && (hold_q == 8'(HOLD_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= force_rel;
         if (new_grant) begin
            hold_q <= '0;
         end else if (state_q == BUSY) begin
            hold_q <= hold_q + 8'd1;
         end
      end
   end
`else
   logic unused_new_grant;

   assign unused_new_grant = new_grant;
   assign force_rel        = 1'b0;
   assign timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_req_arbiter4.sv
// Self-checking bench for req_arbiter4: directed vector table, corner sequences and
// randomized requests compared against a behavioural round-robin model.
module tb_req_arbiter4;

   localparam int HM = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   req_arbiter4 #(.HOLD_MAX(HM)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: owner (-1 = none), round-robin pointer, cycles held so far
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
      m_to    = 1'b0;
   endfunction

   function automatic void model_step(input logic [3:0] r);
      bit rearb;
      rearb = (m_owner < 0);
      m_to  = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            rearb   = 1'b1;
         end else if (TO_EN && m_held == HM) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            rearb   = 1'b1;
            m_to    = 1'b1;
         end else begin
            m_held++;
         end
      end
      if (rearb) begin
         for (int i = 0; i < 4; i++) begin
            if (m_owner < 0 && r[(m_ptr + i) % 4]) begin
               m_owner = (m_ptr + i) % 4;
               m_held  = 1;
            end
         end
      end
   endfunction

   function automatic int enc(input logic [3:0] g);
      int e;
      e = 0;
      for (int i = 0; i < 4; i++) if (g[i]) e = i;
      return e;
   endfunction

   task automatic check_model();
      int eg;
      eg = (m_owner < 0) ? 0 : (1 << m_owner);
      chk("gnt", int'(gnt), eg);
      chk("gnt_idx", int'(gnt_idx), (m_owner < 0) ? 0 : m_owner);
      chk("gnt_vld", int'(gnt_vld), (m_owner < 0) ? 0 : 1);
      chk("timeout", int'(timeout), int'(m_to));
      chk("onehot", int'($countones(gnt) <= 1), 1);
      chk("vld_or", int'(gnt_vld), int'(|gnt));
      chk("idx_enc", int'(gnt_idx), enc(gnt));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(req);
      #1;
      check_model();
   endtask

   // assert reset between edges, check outputs clear at once, release on a falling edge
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_vld", int'(gnt_vld), 0);
      chk("rst_idx", int'(gnt_idx), 0);
      chk("rst_to", int'(timeout), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vt[0] = '{4'b0101, 4'b0001, 2'd0};
      vt[1] = '{4'b0100, 4'b0100, 2'd2};
      vt[2] = '{4'b0000, 4'b0000, 2'd0};
      vt[3] = '{4'b1000, 4'b1000, 2'd3};
      vt[4] = '{4'b1001, 4'b1000, 2'd3};
      vt[5] = '{4'b0011, 4'b0001, 2'd0};
      vt[6] = '{4'b0000, 4'b0000, 2'd0};
      vt[7] = '{4'b1111, 4'b0010, 2'd1};

      #12;
      chk("init_gnt", int'(gnt), 0);
      chk("init_vld", int'(gnt_vld), 0);
      chk("init_to", int'(timeout), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // directed table: back-to-back hand-off, wrap of pointer past 3, no preemption
      for (int v = 0; v < 8; v++) begin
         req = vt[v].req;
         tick();
         chk($sformatf("vec%0d_gnt", v), int'(gnt), int'(vt[v].gnt));
         chk($sformatf("vec%0d_idx", v), int'(gnt_idx), int'(vt[v].idx));
      end

      // rotation with all requesting; each owner holds two cycles then drops once
      req = 4'b0000;
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("rot_idx_a", int'(gnt_idx), k % 4);
         tick();
         chk("rot_idx_b", int'(gnt_idx), k % 4);
         req[k % 4] = 1'b0;
         tick();
         req[k % 4] = 1'b1;
      end

      // reset mid-grant, then a single request
      req = 4'b0100;
      tick();
      tick();
      chk("pre_rst_gnt", int'(gnt), 4);
      req = 4'b0000;
      do_reset();
      req = 4'b0010;
      tick();
      chk("post_rst_idx", int'(gnt_idx), 1);
      chk("post_rst_vld", int'(gnt_vld), 1);

      // sustained two-way contention
      req = 4'b0000;
      do_reset();
      req = 4'b0011;
      tick();
      chk("hold_gnt0", int'(gnt), 1);
`ifdef ARB_TIMEOUT_EN
      for (int c = 1; c < HM; c++) begin
         tick();
         chk("hold_gnt", int'(gnt), 1);
         chk("hold_to", int'(timeout), 0);
      end
      tick();
      chk("to_gnt", int'(gnt), 2);
      chk("to_pulse", int'(timeout), 1);
      tick();
      chk("to_end", int'(timeout), 0);
      chk("to_gnt_after", int'(gnt), 2);
`else
      for (int c = 0; c < 110; c++) begin
         tick();
         chk("hold_gnt", int'(gnt), 1);
         chk("hold_to", int'(timeout), 0);
      end
`endif

      // randomized requests with occasional mid-cycle resets
      req = 4'b0000;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(3) == 0) req[b] = ~req[b];
         end
         tick();
         if ($urandom_range(299) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
